// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and a per-register busy scoreboard.
// Define REGFILE_HW_CLEAR_EN to zero every register in hardware after reset before ready rises.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WR-1:0]          we_i,
    input  logic [NUM_WR*ADDR_W-1:0]   waddr_i,
    input  logic [NUM_WR*DATA_W-1:0]   wdata_i,
    input  logic [NUM_RD-1:0]          re_i,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr_i,
    output logic [NUM_RD*DATA_W-1:0]   rdata_o,
    output logic [NUM_RD-1:0]          rbusy_o,
    input  logic                       set_busy_i,
    input  logic [ADDR_W-1:0]          set_addr_i,
    output logic                       ready_o
);

    localparam int NREGS = 1 << ADDR_W;

    logic [ADDR_W-1:0] waddr [NUM_WR];
    logic [DATA_W-1:0] wdata [NUM_WR];
    logic [ADDR_W-1:0] raddr [NUM_RD];

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [NUM_WR-1:0] wr_commit;
    logic [NUM_RD-1:0] bypass_hit;
    logic [DATA_W-1:0] bypass_data [NUM_RD];
    logic              ready;

    always_comb begin
        for (int i = 0; i < NUM_WR; i++) begin
            waddr[i] = waddr_i[i*ADDR_W +: ADDR_W];
            wdata[i] = wdata_i[i*DATA_W +: DATA_W];
        end
        for (int j = 0; j < NUM_RD; j++) begin
            raddr[j] = raddr_i[j*ADDR_W +: ADDR_W];
        end
    end

`ifdef REGFILE_HW_CLEAR_EN
    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_REG = '1;
    localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= FIRST_REG;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Walk registers 1..last once; the last cleared register releases the pipeline.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST_REG) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ptr_d = ptr_q;
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = FIRST_REG;
            end
        endcase
    end

    assign ready = (state_q == RUN);
`else
    logic ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign ready = ready_q;
`endif

    assign ready_o = ready;

    always_comb begin
        wr_commit = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            wr_commit[i] = we_i[i] && (waddr[i] != '0) && ready && !rst;
        end
    end

    // Ascending port order makes the youngest (highest-index) port win on address collisions.
    always_ff @(posedge clk) begin
`ifdef REGFILE_HW_CLEAR_EN
        if (!rst && state_q == CLEAR) begin
            regs_q[ptr_q] <= '0;
        end
`endif
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_commit[i]) begin
                regs_q[waddr[i]] <= wdata[i];
            end
        end
    end

    // Set is applied after the clears so a newly issued producer overrides a retiring one.
    always_comb begin
        busy_d = busy_q;
        if (ready) begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (we_i[i]) begin
                    busy_d[waddr[i]] = 1'b0;
                end
            end
            if (set_busy_i && set_addr_i != '0) begin
                busy_d[set_addr_i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rdata_o    = '0;
        rbusy_o    = '0;
        bypass_hit = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            bypass_data[j] = '0;
            if (!rst && re_i[j] && raddr[j] != '0) begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (we_i[i] && waddr[i] == raddr[j]) begin
                        bypass_hit[j]  = 1'b1;
                        bypass_data[j] = wdata[i];
                    end
                end
                rbusy_o[j] = busy_q[raddr[j]] & ~bypass_hit[j];
                if (ready) begin
                    rdata_o[j*DATA_W +: DATA_W] = bypass_hit[j] ? bypass_data[j] : regs_q[raddr[j]];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp at default parameters (2 read, 2 write ports).
module tb_regfile_mp;

`ifdef REGFILE_HW_CLEAR_EN
    localparam int EXP_READY = 31;
`else
    localparam int EXP_READY = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        setBusy;
    logic [4:0]  setAddr;
    logic        ready;

    int compareCount  = 0;
    int mismatchCount = 0;
    int cycles;

    regfile_mp dut (
        .clk        (clk),
        .rst        (rst),
        .we_i       (we),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .re_i       (re),
        .raddr_i    (raddr),
        .rdata_o    (rdata),
        .rbusy_o    (rbusy),
        .set_busy_i (setBusy),
        .set_addr_i (setAddr),
        .ready_o    (ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] weV, input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic [4:0] wa1, input logic [31:0] wd1, input logic [1:0] reV,
                                 input logic [4:0] ra0, input logic [4:0] ra1,
                                 input logic sb, input logic [4:0] sa);
        we      = weV;
        waddr   = {wa1, wa0};
        wdata   = {wd1, wd0};
        re      = reV;
        raddr   = {ra1, ra0};
        setBusy = sb;
        setAddr = sa;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady();
        cycles = 0;
        while (!ready && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd7, 1'b0, 5'd0);
        tick();
        tick();
        checkOutput("rstReady", {31'b0, ready}, 32'h0);
        checkOutput("rstRdata0", rdata[31:0], 32'h0);
        checkOutput("rstRbusy", {30'b0, rbusy}, 32'h0);

        // Writes and set_busy to r2 while not ready must be dropped.
        rst = 1'b0;
        applyStimulus(2'b01, 5'd2, 32'hFFFFFFFF, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd2);
        waitReady();
        checkOutput("readyLatency", cycles, EXP_READY);

        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd2, 5'd0, 1'b0, 5'd0);
        checkOutput("notReadySetIgnored", {31'b0, rbusy[0]}, 32'h0);
`ifdef REGFILE_HW_CLEAR_EN
        for (int a = 0; a < 32; a++) begin
            applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'(a), 5'(a), 1'b0, 5'd0);
            checkOutput($sformatf("clr%0dP0", a), rdata[31:0], 32'h0);
            checkOutput($sformatf("clr%0dP1", a), rdata[63:32], 32'h0);
        end
`endif

        tick();
        applyStimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b10, 5'd0, 5'd5, 1'b0, 5'd0);
        checkOutput("bypR5", rdata[63:32], 32'hDEADBEEF);
        tick();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd5, 1'b0, 5'd0);
        checkOutput("arrR5", rdata[63:32], 32'hDEADBEEF);

        applyStimulus(2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 2'b11, 5'd7, 5'd7, 1'b0, 5'd0);
        checkOutput("bypR7P0", rdata[31:0], 32'h22222222);
        checkOutput("bypR7P1", rdata[63:32], 32'h22222222);
        tick();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd5, 1'b0, 5'd0);
        checkOutput("arrR7", rdata[31:0], 32'h22222222);
        checkOutput("arrR5Again", rdata[63:32], 32'hDEADBEEF);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd5, 1'b0, 5'd0);
        checkOutput("reOffP1", rdata[63:32], 32'h0);

        applyStimulus(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 2'b01, 5'd0, 5'd0, 1'b0, 5'd0);
        checkOutput("r0BypData", rdata[31:0], 32'h0);
        checkOutput("r0BypBusy", {31'b0, rbusy[0]}, 32'h0);
        tick();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd0, 5'd0, 1'b1, 5'd0);
        tick();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd0, 5'd0, 1'b0, 5'd0);
        checkOutput("r0Data", rdata[31:0], 32'h0);
        checkOutput("r0Busy", {31'b0, rbusy[0]}, 32'h0);

        applyStimulus(2'b11, 5'd10, 32'h0000AAAA, 5'd11, 32'h0000BBBB, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
        tick();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd10, 5'd11, 1'b0, 5'd0);
        checkOutput("dualR10", rdata[31:0], 32'h0000AAAA);
        checkOutput("dualR11", rdata[63:32], 32'h0000BBBB);

        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd9, 5'd0, 1'b1, 5'd9);
        checkOutput("preSetR9", {31'b0, rbusy[0]}, 32'h0);
        tick();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd9, 1'b0, 5'd0);
        checkOutput("busyR9P0", {31'b0, rbusy[0]}, 32'h1);
        checkOutput("busyR9P1", {31'b0, rbusy[1]}, 32'h1);
        tick();
        applyStimulus(2'b10, 5'd0, 32'h0, 5'd9, 32'hA5A5A5A5, 2'b01, 5'd9, 5'd0, 1'b0, 5'd0);
        checkOutput("wbBusyR9", {31'b0, rbusy[0]}, 32'h0);
        checkOutput("wbDataR9", rdata[31:0], 32'hA5A5A5A5);
        tick();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd9, 5'd0, 1'b0, 5'd0);
        checkOutput("clearedR9", {31'b0, rbusy[0]}, 32'h0);
        checkOutput("arrR9", rdata[31:0], 32'hA5A5A5A5);
        applyStimulus(2'b01, 5'd9, 32'h5A5A5A5A, 5'd0, 32'h0, 2'b01, 5'd9, 5'd0, 1'b1, 5'd9);
        checkOutput("setWrBusyNow", {31'b0, rbusy[0]}, 32'h0);
        checkOutput("setWrData", rdata[31:0], 32'h5A5A5A5A);
        tick();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd9, 5'd0, 1'b0, 5'd0);
        checkOutput("setWinsR9", {31'b0, rbusy[0]}, 32'h1);
        checkOutput("setWinsData", rdata[31:0], 32'h5A5A5A5A);

        applyStimulus(2'b01, 5'd3, 32'h00001234, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3);
        tick();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd3, 5'd0, 1'b0, 5'd0);
        checkOutput("preRstBusyR3", {31'b0, rbusy[0]}, 32'h1);
        checkOutput("preRstDataR3", rdata[31:0], 32'h00001234);
        rst = 1'b1;
        #1;
        checkOutput("midRstData", rdata[31:0], 32'h0);
        checkOutput("midRstBusy", {31'b0, rbusy[0]}, 32'h0);
        checkOutput("midRstReadyHeld", {31'b0, ready}, 32'h1);
        tick();
        checkOutput("midRstReadyDrop", {31'b0, ready}, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        waitReady();
        checkOutput("reReadyLatency", cycles, EXP_READY);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd9, 1'b0, 5'd0);
        checkOutput("postRstBusyR3", {31'b0, rbusy[0]}, 32'h0);
        checkOutput("postRstBusyR9", {31'b0, rbusy[1]}, 32'h0);
`ifdef REGFILE_HW_CLEAR_EN
        checkOutput("postRstDataR3", rdata[31:0], 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
